// File: rtl/cnn_pkg.sv
// Shared constants for the CNN datapath: Q8.8 pixel width and 3x3 window geometry.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int K      = 3;
  localparam int KK     = K * K;

  // Flat index of window element (r, c); r=0 is the oldest row, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c);
    return K * r + c;
  endfunction

endpackage

// File: rtl/line_window_3x3_line_fifo.sv
// Fixed-depth circular line buffer: rd_data is the word pushed DEPTH pushes ago.
module line_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;

  // The slot about to be overwritten holds the oldest word, so read before write.
  assign rd_data = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (wr_en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream using two cascaded line buffers.
// Optional WIN_COORD_EN adds out_row/out_col giving the window centre coordinates.
module line_window_3x3
  import cnn_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            out_valid,
  output logic [KK*N-1:0] win_flat,
  output logic            frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0]   col, cur_col;
  logic [RW-1:0]   row, cur_row;
  logic [N-1:0]    l0_out, l1_out;
  logic [N-1:0]    new_col [K];
  logic [N-1:0]    win     [K][K];
  logic [N-1:0]    nxt     [K][K];
  logic [KK*N-1:0] nxt_flat;
  logic            emit;

  line_fifo #(.W(N), .DEPTH(IMG_W)) u_line0 (
    .clk(clk), .rst_n(rst_n), .wr_en(in_valid), .wr_data(in_data), .rd_data(l0_out)
  );

  line_fifo #(.W(N), .DEPTH(IMG_W)) u_line1 (
    .clk(clk), .rst_n(rst_n), .wr_en(in_valid), .wr_data(l0_out), .rd_data(l1_out)
  );

  // A start pulse makes the pixel accepted in the same cycle position (0,0).
  assign cur_col = start ? '0 : col;
  assign cur_row = start ? '0 : row;
  assign emit    = in_valid && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

  always_comb begin
    new_col[0] = l1_out;
    new_col[1] = l0_out;
    new_col[2] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        nxt[r][c] = (c < K - 1) ? win[r][c+1] : new_col[r];
      end
    end
  end

  always_comb begin
    nxt_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        nxt_flat[win_idx(r, c)*N +: N] = nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_flat   <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      out_valid  <= emit;
      frame_done <= emit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (emit) begin
        win_flat <= nxt_flat;
      end
      if (in_valid) begin
        win <= nxt;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end else if (start) begin
        col <= '0;
        row <= '0;
      end
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (emit) begin
      out_row <= cur_row - RW'(1);
      out_col <= cur_col - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Randomized self-checking bench for line_window_3x3 (4x4 and 5x5 instances) against
// a frame-array reference model; coordinate outputs are checked when WIN_COORD_EN is defined.
module tb_line_window_3x3;

  localparam int NW = 16;
  localparam int FW = 9 * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    st, vl;
  logic [NW-1:0] dat [2];
  logic [1:0]    ov, fd;
  logic [FW-1:0] wf  [2];
`ifdef WIN_COORD_EN
  logic [1:0] or4, oc4;
  logic [2:0] or5, oc5;
`endif

  always #5 clk = ~clk;

  line_window_3x3 #(.N(NW), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vl[0]), .in_data(dat[0]),
    .out_valid(ov[0]), .win_flat(wf[0]), .frame_done(fd[0])
`ifdef WIN_COORD_EN
    , .out_row(or4), .out_col(oc4)
`endif
  );

  line_window_3x3 #(.N(NW), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vl[1]), .in_data(dat[1]),
    .out_valid(ov[1]), .win_flat(wf[1]), .frame_done(fd[1])
`ifdef WIN_COORD_EN
    , .out_row(or5), .out_col(oc5)
`endif
  );

  int total = 0;
  int bad   = 0;
  int win_cnt, done_cnt;

  // Reference model: current frame stored as an image, window read straight from it.
  int          wdt [2] = '{4, 5};
  int          pos [2];
  logic [NW-1:0] img [2][5][5];
  logic [FW-1:0] e_win [2];
  bit          e_val [2], e_done [2];
  int          e_r [2], e_c [2];

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; e_win[d] = '0; e_val[d] = 0; e_done[d] = 0; e_r[d] = 0; e_c[d] = 0;
    end
  endtask

  task automatic modelStep(input int d, input bit v, input logic [NW-1:0] x, input bit s);
    int w, r, c;
    w = wdt[d];
    if (s) pos[d] = 0;
    e_val[d] = 0;
    e_done[d] = 0;
    if (v) begin
      r = pos[d] / w;
      c = pos[d] % w;
      img[d][r][c] = x;
      if (r >= 2 && c >= 2) begin
        e_val[d] = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e_win[d][(3*i+j)*NW +: NW] = img[d][r-2+i][c-2+j];
        e_done[d] = (r == w - 1) && (c == w - 1);
        e_r[d] = r - 1;
        e_c[d] = c - 1;
      end
      pos[d] = (pos[d] + 1) % (w * w);
    end
  endtask

  task automatic checkAll(input int d);
    checkOutput("out_valid", FW'(ov[d]), FW'(e_val[d]));
    checkOutput("frame_done", FW'(fd[d]), FW'(e_done[d]));
    checkOutput("win_flat", wf[d], e_win[d]);
`ifdef WIN_COORD_EN
    checkOutput("out_row", d ? FW'(or5) : FW'(or4), FW'(e_r[d]));
    checkOutput("out_col", d ? FW'(oc5) : FW'(oc4), FW'(e_c[d]));
`endif
    if (ov[d]) win_cnt++;
    if (fd[d]) done_cnt++;
  endtask

  // Drive one cycle at the negedge, model the posedge, check at the following negedge.
  task automatic applyStimulus(input int d, input bit v, input logic [NW-1:0] x, input bit s);
    st[d] = s; vl[d] = v; dat[d] = x;
    @(posedge clk);
    modelStep(d, v, x, s);
    modelStep(1 - d, 1'b0, '0, 1'b0);
    @(negedge clk);
    st[d] = 1'b0; vl[d] = 1'b0; dat[d] = NW'($urandom);
    checkAll(d);
  endtask

  task automatic sendPixels(input int d, input int first, input int last, input bit neg,
                            input int maxgap, input bit st_first);
    logic [NW-1:0] px;
    int gaps;
    for (int i = first; i <= last; i++) begin
      gaps = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
      for (int g = 0; g < gaps; g++) applyStimulus(d, 1'b0, NW'($urandom), 1'b0);
      px = neg ? NW'(-(i << 8)) : NW'(i << 8);
      applyStimulus(d, 1'b1, px, st_first && (i == first));
    end
  endtask

  function automatic logic [FW-1:0] packList(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int lst [9];
    logic [FW-1:0] v;
    lst = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    v = '0;
    for (int k = 0; k < 9; k++) v[k*NW +: NW] = NW'(lst[k] << 8);
    return v;
  endfunction

  task automatic startCount();
    win_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic checkCounts(input string tag, input int wins, input int dones);
    checkOutput({tag, "_windows"}, FW'(win_cnt), FW'(wins));
    checkOutput({tag, "_frame_done"}, FW'(done_cnt), FW'(dones));
  endtask

  initial begin
    st = '0; vl = '0; dat[0] = '0; dat[1] = '0;
    rst_n = 1'b0;
    modelReset();
    win_cnt = 0; done_cnt = 0;
    #2;
    checkAll(0);
    checkAll(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 4x4 frame, continuous valid");
    startCount();
    sendPixels(0, 0, 10, 1'b0, 0, 1'b0);
    checkOutput("first_window", wf[0], packList(0, 1, 2, 4, 5, 6, 8, 9, 10));
    sendPixels(0, 11, 15, 1'b0, 0, 1'b0);
    checkOutput("last_window", wf[0], packList(5, 6, 7, 9, 10, 11, 13, 14, 15));
    checkOutput("last_frame_done", FW'(fd[0]), FW'(1));
    checkCounts("plain", 4, 1);

    $display("[TB] 4x4 frame with random gaps");
    startCount();
    sendPixels(0, 0, 15, 1'b0, 3, 1'b0);
    checkCounts("gaps", 4, 1);

    $display("[TB] back-to-back frames, second negative");
    startCount();
    sendPixels(0, 0, 15, 1'b0, 1, 1'b0);
    sendPixels(0, 0, 15, 1'b1, 2, 1'b0);
    checkCounts("b2b", 8, 2);

    $display("[TB] start aborts a frame");
    startCount();
    sendPixels(0, 0, 9, 1'b0, 1, 1'b0);
    sendPixels(0, 0, 15, 1'b1, 1, 1'b1);
    checkCounts("abort", 4, 1);

    $display("[TB] asynchronous reset mid-frame");
    sendPixels(0, 0, 10, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_out_valid", FW'(ov[0]), FW'(0));
    checkOutput("rst_frame_done", FW'(fd[0]), FW'(0));
    checkOutput("rst_win_flat", wf[0], '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkAll(0);
    startCount();
    sendPixels(0, 0, 15, 1'b0, 2, 1'b0);
    checkCounts("post_reset", 4, 1);

    $display("[TB] 5x5 frame with gaps");
    startCount();
    sendPixels(1, 0, 24, 1'b0, 2, 1'b0);
    checkCounts("img5", 9, 1);
    sendPixels(1, 0, 24, 1'b1, 0, 1'b0);

    repeat (3) applyStimulus(0, 1'b0, NW'($urandom), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Streaming 3x3 sliding-window generator directly downstream of the input selector mux.
- Consumes one signed Q8.8 pixel per accepted cycle in raster order.
- Buffers two full image lines and emits a packed 3x3 window each time a valid (no-padding) convolution position completes.
- Feeds the convolution engine.

Parameters:
- N, 16, pixel width (Q8.8, signed).
- IMG_W, 28, image width in pixels; must be ≥3.
- IMG_H, 28, image height in pixels; must be ≥3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous frame-start pulse; clears position counters.
- in_valid  in  1  in_data is a valid pixel this cycle.
- in_data  in  N  signed Q8.8 pixel from the input selector mux.
- out_valid  out  1  win_flat holds a new window this cycle (1-cycle pulse per window).
- win_flat  out  9*N  packed window; element k=3*r+c at bits [k*N +: N]; r=0 is the oldest row, c=0 is the oldest column.
- frame_done  out  1  1-cycle pulse, asserted with the output for the last pixel of a frame.

Behaviour:
- Reset (rst_n=0, async): all of the following clear to 0:
  - out_valid, win_flat, frame_done;
  - col/row counters;
  - 3x3 window registers.
  - Line-buffer RAM contents are don't-care.
- Storage:
  - Two line FIFOs, each IMG_W deep and N wide, in cascade: line0 output feeds line1 input.
  - Window register array of 3 rows x 3 cols.
- Per accepted pixel (in_valid=1):
  - Each window row shifts left by one column.
  - New column: row2 ← in_data; row1 ← line0 output; row0 ← line1 output.
  - Then line0 pushes in_data and line1 pushes the old line0 output.
  - Accepted pixels only; no data movement when in_valid=0.
- Counters:
  - col increments per accepted pixel.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
- Output:
  - out_valid is registered and asserted exactly one cycle after accepting a pixel whose (row,col) satisfies row≥2 and col≥2.
  - Window centre = (row-1, col-1).
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
  - Latency from accepting the bottom-right pixel of a window to out_valid is 1 cycle.
- win_flat holds its last value while out_valid=0.
- frame_done pulses in the same cycle as out_valid for pixel (IMG_H-1, IMG_W-1).
- in_valid gaps of any length are allowed; the window state is preserved across them.
- No backpressure: the consumer must accept every out_valid pulse.
- start behaviour:
  - start=1 zeroes the counters. If in_valid is also high that cycle, the pixel is accepted as (0,0).
  - Stale line-buffer data is never emitted, because row<2 gates out_valid.
  - start mid-frame abandons the current frame with no frame_done.
- Back-to-back frames without start are legal; the counter wrap handles them.
- Arithmetic: pure data movement; no saturation. Values pass bit-exact, including negatives.

Optional Feature:
- WIN_COORD_EN defined:
  - Adds outputs out_row [$clog2(IMG_H)-1:0] and out_col [$clog2(IMG_W)-1:0].
  - They give the window centre coordinates, registered alongside win_flat, and reset to 0.
- WIN_COORD_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - Q8.8 width constant DATA_W=16;
  - window size constant K=3;
  - packed window index helper constants (K*K=9).
- One sub-module, line_fifo:
  - IMG_W-deep shift/circular buffer with a write-enable;
  - read data equals the value pushed IMG_W pushes earlier.
  - Instantiated twice.

Test Plan:
- IMG_W=IMG_H=4, pixel i = i<<8 (i=0..15), in_valid held high → 4 windows.
  - First window, one cycle after pixel 10: {0,1,2,4,5,6,8,9,10}<<8.
  - Last window: {5,6,7,9,10,11,13,14,15}<<8, with frame_done in the same cycle.
- Same stream with random 0–3 cycle in_valid gaps → identical window sequence; out_valid never asserted during gaps.
- Two frames back-to-back, second frame pixel i = -(i<<8) → 8 windows total, 2 frame_done pulses, and second-frame windows have exact negative values.
- start asserted after pixel 9 of frame 1, then a full new frame → no window from the aborted frame, next 4 windows match the fresh frame, no spurious frame_done.
- rst_n low for 1 cycle mid-frame, asynchronously between edges → outputs go to 0 immediately; a subsequent full frame yields the correct 4 windows.
- With WIN_COORD_EN, 5x5 image → 9 windows with (out_row,out_col) from (1,1) through (3,3) in raster order.
